// File: rtl/y86_pkg.sv
// Shared encodings for the Y86-64 pipeline control slice: icodes, status codes,
// the "no register" id and the run/halt state type.
package y86_pkg;

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] S_AOK = 4'h1;
  localparam logic [3:0] S_HLT = 4'h2;
  localparam logic [3:0] S_ADR = 4'h3;
  localparam logic [3:0] S_INS = 4'h4;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } ctrl_state_t;

  // Any status that must stop younger instructions from updating state.
  function automatic logic is_exc_stat(input logic [3:0] stat);
    return (stat == S_ADR) || (stat == S_INS) || (stat == S_HLT);
  endfunction

endpackage

// File: rtl/pipe_hazard.sv
// Combinational hazard detection: load/use, ret in flight, mispredicted jXX
// and exceptional status in the M/W stages.
module pipe_hazard (
  input  logic [3:0] D_icode,
  input  logic [3:0] E_icode,
  input  logic [3:0] M_icode,
  input  logic [3:0] d_srcA,
  input  logic [3:0] d_srcB,
  input  logic [3:0] E_dstM,
  input  logic       e_Cnd,
  input  logic [3:0] m_stat,
  input  logic [3:0] W_stat,
  output logic       loaduse,
  output logic       ret,
  output logic       mispred,
  output logic       exc_mw
);
  import y86_pkg::*;

  logic e_is_load;
  logic dst_hit;

  // Only a real load destination can collide; RNONE never matches a source.
  always_comb begin
    e_is_load = (E_icode == I_MRMOVQ) || (E_icode == I_POPQ);
    dst_hit   = (E_dstM != RNONE) && ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    loaduse   = e_is_load && dst_hit;
    ret       = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    mispred   = (E_icode == I_JXX) && !e_Cnd;
    exc_mw    = is_exc_stat(m_stat) || is_exc_stat(W_stat);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: run/halt FSM, stall/bubble generation with data-memory
// freeze override, freeze watchdog and cycle/retire performance counters.
module pipe_ctrl #(
  parameter int WAIT_MAX = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  D_icode,
  input  logic [3:0]  E_icode,
  input  logic [3:0]  M_icode,
  input  logic [3:0]  W_icode,
  input  logic [3:0]  d_srcA,
  input  logic [3:0]  d_srcB,
  input  logic [3:0]  E_dstM,
  input  logic        e_Cnd,
  input  logic [3:0]  m_stat,
  input  logic [3:0]  W_stat,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        F_stall,
  output logic        D_stall,
  output logic        W_stall,
  output logic        D_bubble,
  output logic        E_bubble,
  output logic        M_bubble,
  output logic        set_cc,
  output logic [3:0]  cpu_stat,
  output logic        halted,
  output logic [63:0] cycle_cnt,
  output logic [63:0] retired_cnt
);
  import y86_pkg::*;

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  ctrl_state_t state;
  ctrl_state_t next_state;
  logic [7:0]  wait_cnt;

  logic loaduse;
  logic ret;
  logic mispred;
  logic exc_mw;
  logic freeze;
  logic wdog_expire;
  logic w_fault;
  logic retire;

  pipe_hazard u_hazard (
    .D_icode (D_icode),
    .E_icode (E_icode),
    .M_icode (M_icode),
    .d_srcA  (d_srcA),
    .d_srcB  (d_srcB),
    .E_dstM  (E_dstM),
    .e_Cnd   (e_Cnd),
    .m_stat  (m_stat),
    .W_stat  (W_stat),
    .loaduse (loaduse),
    .ret     (ret),
    .mispred (mispred),
    .exc_mw  (exc_mw)
  );

  // wait_cnt holds the number of earlier consecutive frozen cycles, so this
  // cycle is the WAIT_MAX-th one when it equals WAIT_MAX-1.
  always_comb begin
    freeze      = dmem_req && !dmem_ready;
    wdog_expire = freeze && (wait_cnt == WAIT_LAST);
    w_fault     = (W_stat != S_AOK);
    retire      = (state == RUN) && !freeze && !w_fault && (W_icode != I_NOP);
    halted      = (state == HALTED);
  end

  always_comb begin
    next_state = state;
    F_stall    = 1'b1;
    D_stall    = 1'b1;
    W_stall    = 1'b1;
    D_bubble   = 1'b0;
    E_bubble   = 1'b0;
    M_bubble   = 1'b0;
    set_cc     = 1'b0;

    case (state)
      IDLE: begin
        if (start) next_state = RUN;
      end
      RUN: begin
        // A frozen memory stage holds the whole pipe; hazards wait it out.
        if (!freeze) begin
          F_stall  = loaduse || ret;
          D_stall  = loaduse;
          D_bubble = mispred || (!loaduse && ret);
          E_bubble = mispred || loaduse;
          M_bubble = exc_mw;
          W_stall  = w_fault;
          set_cc   = (E_icode == I_OPQ) && (m_stat == S_AOK) && !w_fault;
        end
        if (w_fault || wdog_expire) next_state = HALTED;
      end
      HALTED: begin
        next_state = HALTED;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cpu_stat    <= S_AOK;
      cycle_cnt   <= '0;
      retired_cnt <= '0;
      wait_cnt    <= '0;
    end else begin
      state <= next_state;
      if (state == RUN) begin
        cycle_cnt <= cycle_cnt + 64'd1;
        if (retire) retired_cnt <= retired_cnt + 64'd1;
        wait_cnt <= freeze ? wait_cnt + 8'd1 : 8'd0;
        // The writeback status is the architecturally precise cause.
        if (w_fault) begin
          cpu_stat <= W_stat;
        end else if (wdog_expire) begin
          cpu_stat <= S_ADR;
        end
      end else begin
        wait_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a reference model queues expected outputs per
// driven cycle, which are popped and compared against the DUT before the edge.
module tb_pipe_ctrl;
  import y86_pkg::*;

  localparam int WAIT_MAX = 16;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [3:0]  D_icode, E_icode, M_icode, W_icode;
  logic [3:0]  d_srcA, d_srcB, E_dstM;
  logic        e_Cnd;
  logic [3:0]  m_stat, W_stat;
  logic        dmem_req, dmem_ready;
  logic        F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc;
  logic [3:0]  cpu_stat;
  logic        halted;
  logic [63:0] cycle_cnt, retired_cnt;

  always #5 clk = ~clk;

  pipe_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode), .W_icode(W_icode),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
    .m_stat(m_stat), .W_stat(W_stat), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .F_stall(F_stall), .D_stall(D_stall), .W_stall(W_stall),
    .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble),
    .set_cc(set_cc), .cpu_stat(cpu_stat), .halted(halted),
    .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt)
  );

  typedef struct packed {
    logic       rst_n;
    logic       start;
    logic [3:0] D_icode, E_icode, M_icode, W_icode;
    logic [3:0] d_srcA, d_srcB, E_dstM;
    logic       e_Cnd;
    logic [3:0] m_stat, W_stat;
    logic       dmem_req, dmem_ready;
  } stim_t;

  typedef struct packed {
    logic        F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc;
    logic        halted;
    logic [3:0]  cpu_stat;
    logic [63:0] cycle_cnt, retired_cnt;
  } exp_t;

  int total = 0;
  int bad = 0;
  exp_t sb_q[$];

  ctrl_state_t m_state;
  logic [3:0]  m_cpu;
  logic [63:0] m_cycle, m_ret;
  int          m_wait;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic stim_t quietStim();
    stim_t s;
    s.rst_n = 1'b1;        s.start = 1'b0;
    s.D_icode = I_NOP;     s.E_icode = I_NOP;  s.M_icode = I_NOP;  s.W_icode = I_NOP;
    s.d_srcA = RNONE;      s.d_srcB = RNONE;   s.E_dstM = RNONE;
    s.e_Cnd = 1'b1;        s.m_stat = S_AOK;   s.W_stat = S_AOK;
    s.dmem_req = 1'b0;     s.dmem_ready = 1'b1;
    return s;
  endfunction

  function automatic exp_t modelExpect(input stim_t s);
    exp_t e;
    logic lu, rt, mp, ex;
    e.F_stall = 1'b1;  e.D_stall = 1'b1;  e.W_stall = 1'b1;
    e.D_bubble = 1'b0; e.E_bubble = 1'b0; e.M_bubble = 1'b0; e.set_cc = 1'b0;
    e.halted = (m_state == HALTED);
    e.cpu_stat = m_cpu;
    e.cycle_cnt = m_cycle;
    e.retired_cnt = m_ret;
    if (m_state == RUN && !(s.dmem_req && !s.dmem_ready)) begin
      lu = (s.E_icode == I_MRMOVQ || s.E_icode == I_POPQ) && s.E_dstM != RNONE &&
           (s.E_dstM == s.d_srcA || s.E_dstM == s.d_srcB);
      rt = (s.D_icode == I_RET) || (s.E_icode == I_RET) || (s.M_icode == I_RET);
      mp = (s.E_icode == I_JXX) && !s.e_Cnd;
      ex = (s.m_stat inside {S_ADR, S_INS, S_HLT}) || (s.W_stat inside {S_ADR, S_INS, S_HLT});
      e.F_stall  = lu || rt;
      e.D_stall  = lu;
      e.D_bubble = mp || (!lu && rt);
      e.E_bubble = mp || lu;
      e.M_bubble = ex;
      e.W_stall  = (s.W_stat != S_AOK);
      e.set_cc   = (s.E_icode == I_OPQ) && (s.m_stat == S_AOK) && (s.W_stat == S_AOK);
    end
    return e;
  endfunction

  task automatic modelReset();
    m_state = IDLE; m_cpu = S_AOK; m_cycle = 64'd0; m_ret = 64'd0; m_wait = 0;
  endtask

  task automatic modelAdvance(input stim_t s);
    logic fz;
    fz = s.dmem_req && !s.dmem_ready;
    if (!s.rst_n) begin
      modelReset();
    end else if (m_state == IDLE) begin
      if (s.start) m_state = RUN;
      m_wait = 0;
    end else if (m_state == RUN) begin
      m_cycle = m_cycle + 64'd1;
      if (!fz && s.W_stat == S_AOK && s.W_icode != I_NOP) m_ret = m_ret + 64'd1;
      if (s.W_stat != S_AOK) begin
        m_state = HALTED; m_cpu = s.W_stat;
      end else if (fz && m_wait + 1 == WAIT_MAX) begin
        m_state = HALTED; m_cpu = S_ADR;
      end
      m_wait = fz ? m_wait + 1 : 0;
    end else begin
      m_wait = 0;
    end
  endtask

  task automatic applyStimulus(input string tag, input stim_t s);
    exp_t e;
    @(negedge clk);
    rst_n = s.rst_n; start = s.start;
    D_icode = s.D_icode; E_icode = s.E_icode; M_icode = s.M_icode; W_icode = s.W_icode;
    d_srcA = s.d_srcA; d_srcB = s.d_srcB; E_dstM = s.E_dstM; e_Cnd = s.e_Cnd;
    m_stat = s.m_stat; W_stat = s.W_stat; dmem_req = s.dmem_req; dmem_ready = s.dmem_ready;
    sb_q.push_back(modelExpect(s));
    #2;
    e = sb_q.pop_front();
    checkOutput({tag, ".F_stall"},  64'(F_stall),  64'(e.F_stall));
    checkOutput({tag, ".D_stall"},  64'(D_stall),  64'(e.D_stall));
    checkOutput({tag, ".W_stall"},  64'(W_stall),  64'(e.W_stall));
    checkOutput({tag, ".D_bubble"}, 64'(D_bubble), 64'(e.D_bubble));
    checkOutput({tag, ".E_bubble"}, 64'(E_bubble), 64'(e.E_bubble));
    checkOutput({tag, ".M_bubble"}, 64'(M_bubble), 64'(e.M_bubble));
    checkOutput({tag, ".set_cc"},   64'(set_cc),   64'(e.set_cc));
    checkOutput({tag, ".halted"},   64'(halted),   64'(e.halted));
    checkOutput({tag, ".cpu_stat"}, 64'(cpu_stat), 64'(e.cpu_stat));
    checkOutput({tag, ".cycle"},    cycle_cnt,     e.cycle_cnt);
    checkOutput({tag, ".retired"},  retired_cnt,   e.retired_cnt);
    @(posedge clk);
    #1;
    modelAdvance(s);
  endtask

  task automatic resetAndStart();
    stim_t s;
    s = quietStim(); s.rst_n = 1'b0;
    applyStimulus("rst", s);
    s = quietStim(); s.start = 1'b1;
    applyStimulus("start", s);
  endtask

  initial begin
    stim_t s;
    logic [3:0] w_seq [10];

    rst_n = 1'b0; start = 1'b0;
    D_icode = I_NOP; E_icode = I_NOP; M_icode = I_NOP; W_icode = I_NOP;
    d_srcA = RNONE; d_srcB = RNONE; E_dstM = RNONE; e_Cnd = 1'b1;
    m_stat = S_AOK; W_stat = S_AOK; dmem_req = 1'b0; dmem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    modelReset();

    s = quietStim(); s.rst_n = 1'b0;
    applyStimulus("reset", s);
    s = quietStim(); s.E_icode = I_MRMOVQ; s.E_dstM = 4'd3; s.d_srcB = 4'd3;
    applyStimulus("idle_lu", s);
    s = quietStim(); s.start = 1'b1;
    applyStimulus("start", s);

    // Ten RUN cycles, six of which retire a non-NOP instruction.
    w_seq = '{I_OPQ, I_NOP, I_MRMOVQ, I_JXX, I_NOP, I_OPQ, I_NOP, I_POPQ, I_NOP, I_RET};
    for (int i = 0; i < 10; i++) begin
      s = quietStim(); s.W_icode = w_seq[i];
      applyStimulus("retire", s);
    end
    checkOutput("cycle10", cycle_cnt, 64'd10);
    checkOutput("retired6", retired_cnt, 64'd6);
    s = quietStim(); s.rst_n = 1'b0; s.W_icode = I_OPQ;
    applyStimulus("midrun_rst", s);
    checkOutput("rst_cycle0", cycle_cnt, 64'd0);
    checkOutput("rst_retired0", retired_cnt, 64'd0);
    applyStimulus("idle_after_rst", quietStim());
    s = quietStim(); s.start = 1'b1;
    applyStimulus("restart", s);
    s = quietStim(); s.start = 1'b1;
    applyStimulus("start_in_run", s);

    s = quietStim(); s.E_icode = I_MRMOVQ; s.E_dstM = 4'd3; s.d_srcB = 4'd3;
    applyStimulus("loaduse", s);
    s = quietStim(); s.E_icode = I_POPQ; s.E_dstM = 4'd5; s.d_srcA = 4'd5;
    applyStimulus("lu_popq", s);
    s = quietStim(); s.E_icode = I_MRMOVQ;
    applyStimulus("lu_rnone", s);
    s = quietStim(); s.E_icode = I_MRMOVQ; s.E_dstM = 4'd4; s.d_srcA = 4'd3; s.d_srcB = 4'd2;
    applyStimulus("lu_nomatch", s);
    s = quietStim(); s.E_icode = I_JXX; s.e_Cnd = 1'b0; s.D_icode = I_RET;
    applyStimulus("mispred_ret", s);
    s = quietStim(); s.E_icode = I_JXX; s.e_Cnd = 1'b1;
    applyStimulus("jxx_taken", s);
    s = quietStim(); s.D_icode = I_RET;
    applyStimulus("ret_D", s);
    s = quietStim(); s.E_icode = I_RET;
    applyStimulus("ret_E", s);
    s = quietStim(); s.M_icode = I_RET;
    applyStimulus("ret_M", s);
    applyStimulus("ret_done", quietStim());
    s = quietStim(); s.E_icode = I_MRMOVQ; s.E_dstM = 4'd2; s.d_srcA = 4'd2; s.M_icode = I_RET;
    applyStimulus("lu_ret", s);
    s = quietStim(); s.E_icode = I_OPQ; s.W_icode = I_OPQ;
    applyStimulus("setcc", s);
    s = quietStim(); s.E_icode = I_OPQ; s.m_stat = S_ADR;
    applyStimulus("setcc_madr", s);
    s = quietStim(); s.E_icode = I_OPQ; s.m_stat = S_INS;
    applyStimulus("setcc_mins", s);
    s = quietStim(); s.dmem_req = 1'b1; s.dmem_ready = 1'b1; s.W_icode = I_MRMOVQ;
    applyStimulus("req_ready", s);

    // Fifteen frozen cycles with hazards present, released on the sixteenth.
    for (int i = 0; i < 15; i++) begin
      s = quietStim(); s.dmem_req = 1'b1; s.dmem_ready = 1'b0;
      s.E_icode = I_JXX; s.e_Cnd = 1'b0; s.D_icode = I_RET; s.W_icode = I_OPQ;
      applyStimulus("freeze_short", s);
    end
    s = quietStim(); s.dmem_req = 1'b1; s.dmem_ready = 1'b1; s.W_icode = I_OPQ;
    applyStimulus("freeze_release", s);
    checkOutput("wd_short_run", 64'(halted), 64'd0);

    for (int i = 0; i < WAIT_MAX; i++) begin
      s = quietStim(); s.dmem_req = 1'b1; s.dmem_ready = 1'b0; s.W_icode = I_OPQ;
      applyStimulus("freeze_full", s);
    end
    checkOutput("wd_halted", 64'(halted), 64'd1);
    checkOutput("wd_cpu_adr", 64'(cpu_stat), 64'(S_ADR));
    for (int i = 0; i < 3; i++) begin
      s = quietStim(); s.start = 1'b1; s.W_icode = I_OPQ; s.E_icode = I_OPQ;
      applyStimulus("halted_hold", s);
    end

    // Watchdog expiry and a writeback fault in the same cycle.
    resetAndStart();
    for (int i = 0; i < WAIT_MAX; i++) begin
      s = quietStim(); s.dmem_req = 1'b1; s.dmem_ready = 1'b0;
      if (i == WAIT_MAX - 1) s.W_stat = S_INS;
      applyStimulus("wd_vs_ins", s);
    end
    checkOutput("ins_wins", 64'(cpu_stat), 64'(S_INS));

    resetAndStart();
    for (int i = 0; i < 4; i++) begin
      s = quietStim(); s.dmem_req = 1'b1; s.dmem_ready = 1'b0;
      applyStimulus("freeze_pre_rst", s);
    end
    s = quietStim(); s.dmem_req = 1'b1; s.dmem_ready = 1'b0; s.rst_n = 1'b0;
    applyStimulus("freeze_rst", s);
    s = quietStim(); s.start = 1'b1;
    applyStimulus("start2", s);
    s = quietStim(); s.W_icode = I_OPQ;
    applyStimulus("pre_hlt", s);
    s = quietStim(); s.W_stat = S_HLT; s.W_icode = I_OPQ;
    applyStimulus("w_hlt", s);
    checkOutput("hlt_halted", 64'(halted), 64'd1);
    checkOutput("hlt_cpu", 64'(cpu_stat), 64'(S_HLT));
    for (int i = 0; i < 3; i++) begin
      s = quietStim(); s.W_icode = I_OPQ;
      applyStimulus("post_hlt", s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage Y86-64 core. Each cycle it decides the stall and bubble signals for the F/D/E/M/W pipeline registers from the hazard conditions:

- load/use
- ret
- mispredicted jXX
- exceptions

It also decides the condition-code write enable. Around that it runs a small run/halt state machine, a data-memory wait freeze with watchdog, and cycle/retire counters. It sits beside the pipeline registers and the d_valA/d_valB forwarding muxes; those muxes resolve every data hazard except load/use, which this block resolves.

## Interface
Parameters:
- WAIT_MAX, 16: consecutive data-memory wait cycles tolerated before a forced ADR halt (range 2..255).

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  pulse; leaves IDLE
- D_icode, E_icode, M_icode, W_icode  in  4 each  stage icodes
- d_srcA, d_srcB  in  4 each  decode source registers (0xF = none)
- E_dstM  in  4  execute-stage load destination
- e_Cnd  in  1  branch condition from execute
- m_stat, W_stat  in  4 each  memory/writeback status
- dmem_req  in  1  M stage accessing data memory this cycle
- dmem_ready  in  1  data memory completes this cycle
- F_stall, D_stall, W_stall  out  1 each  hold register
- D_bubble, E_bubble, M_bubble  out  1 each  insert nop
- set_cc  out  1  CC write enable
- cpu_stat  out  4  sticky processor status
- halted  out  1  state == HALTED
- cycle_cnt, retired_cnt  out  64 each  performance counters

## Operation
Icode and status encodings:
- Icodes: NOP=1, JXX=7, CALL=8, RET=9, MRMOVQ=5, OPQ=6, POPQ=0xB.
- Status codes: AOK=1, HLT=2, ADR=3, INS=4.

Hazard terms (combinational):
- loaduse = E_icode in {MRMOVQ, POPQ} && E_dstM != 0xF && E_dstM in {d_srcA, d_srcB}
- ret = RET in {D_icode, E_icode, M_icode}
- mispred = E_icode == JXX && !e_Cnd
- exc_mw = m_stat or W_stat in {ADR, INS, HLT}
- freeze = dmem_req && !dmem_ready

Outputs in RUN with freeze=0:
- F_stall = loaduse || ret
- D_stall = loaduse
- D_bubble = mispred || (!loaduse && ret)
- E_bubble = mispred || loaduse
- M_bubble = exc_mw
- W_stall = W_stat != AOK
- set_cc = E_icode == OPQ && m_stat == AOK && W_stat == AOK

In IDLE, in HALTED, or when freeze=1 in RUN:
- F_stall, D_stall and W_stall = 1.
- All bubbles and set_cc = 0.

FSM states IDLE, RUN, HALTED:
- IDLE → RUN on start.
- RUN → HALTED when W_stat != AOK; cpu_stat ← W_stat.
- RUN → HALTED when freeze holds for WAIT_MAX consecutive cycles; cpu_stat ← ADR. If W_stat != AOK in that same cycle, W_stat wins.
- HALTED is left only by reset.
- start outside IDLE is ignored.

Counters and wait counter:
- wait_cnt (8-bit, internal) increments on each RUN cycle with freeze=1 and clears otherwise.
- cycle_cnt increments on every RUN cycle.
- retired_cnt increments on RUN cycles with freeze=0, W_stat == AOK and W_icode != NOP.
- Both 64-bit counters wrap modulo 2^64.

## Timing
- Control outputs are combinational from the inputs and the current state, valid in the same cycle.
- State, cpu_stat, counters and wait_cnt update on the rising edge of clk.
- Reset values: state IDLE, cpu_stat = AOK, halted = 0, counters = 0, wait_cnt = 0. Resulting outputs: F/D/W_stall = 1, bubbles = 0, set_cc = 0.
- Reset asserted mid-RUN or mid-freeze takes effect at the next edge.
- Halt latency: W_stat != AOK at cycle n → W_stall = 1 in cycle n, then halted = 1 and cpu_stat valid from n+1.
- ret penalty: 3 fetch-stall cycles with D bubbles while RET is in D, E and M.
- load/use penalty: 1 cycle.
- Mispredict penalty: 2 squashed instructions (D and E bubbled in one cycle).
- freeze overrides every hazard term and counts as a cycle, not a retirement.

## Structure
- Package y86_pkg holds:
  - icode constants
  - stat codes
  - RNONE = 4'hF
  - FSM state enum
- One sub-module, pipe_hazard, is the natural split: purely combinational, it produces loaduse/ret/mispred/exc_mw.
- pipe_ctrl owns the FSM, freeze override, watchdog and counters.

## Test plan
- E_icode=MRMOVQ, E_dstM=3, d_srcB=3 → F_stall=D_stall=E_bubble=1, D_bubble=0 for one cycle.
- E_icode=JXX, e_Cnd=0, D_icode=RET → D_bubble=E_bubble=1, F_stall=1.
- RET walks D→E→M over 3 cycles → F_stall=1 and D_bubble=1 each cycle; cycle 4 all 0.
- W_stat=HLT in RUN at cycle n → W_stall=1 at n; halted=1, cpu_stat=2 at n+1; counters frozen thereafter.
- dmem_req=1, dmem_ready=0 for 16 cycles, WAIT_MAX=16 → all stalls high throughout, then halted=1 and cpu_stat=3. With ready at cycle 15, RUN continues and wait_cnt clears.
- After start: 10 cycles with 6 non-NOP AOK W instructions → cycle_cnt=10, retired_cnt=6. rst_n=0 for one edge → both 0, state IDLE.
